// File: rtl/qbus_io_bridge.sv
// QBUS slave handshake to internal I/O register bus bridge (DATI, DATO, DATIO; no RPLY on unclaimed addresses).
// Optional build macro QBRIDGE_RPLY_DELAY_EN: assert TRPLY one qclk after read data / the write strobe.
module qbus_io_bridge #(
    parameter int SYNC_STAGES = 2
) (
    input  logic        qclk,
    input  logic        qrst_n,
    output logic        DALtx,
    inout  wire  [21:0] DAL,
    input  logic        RBS7,
    input  logic        RSYNC,
    input  logic        RDIN,
    input  logic        RDOUT,
    output logic        TRPLY,
    output logic [12:0] iADDR,
    output logic        iBS7,
    input  logic        iREAD_MATCH,
    input  logic        iWRITE_MATCH,
    output logic [15:0] iWDATA,
    output logic        iWRITE,
    input  logic [15:0] iRDATA
);

    // A single-flop synchroniser is never acceptable, so smaller values are clamped.
    localparam int STAGES = (SYNC_STAGES < 2) ? 2 : SYNC_STAGES;

`ifdef QBRIDGE_RPLY_DELAY_EN
    localparam logic RPLY_IMMEDIATE = 1'b0;
`else
    localparam logic RPLY_IMMEDIATE = 1'b1;
`endif

    typedef enum logic [2:0] {
        IDLE  = 3'd0,
        ADDR  = 3'd1,
        READ  = 3'd2,
        WRITE = 3'd3,
        NXM   = 3'd4
    } state_t;

    state_t            state_r;
    logic [15:0]       dalQ1_r;
    logic              bs7Q1_r;
    logic [STAGES-1:0] syncPipe_r;
    logic [STAGES-1:0] dinPipe_r;
    logic [STAGES-1:0] doutPipe_r;
    logic [15:0]       rdBuf_r;

    logic sSYNC;
    logic sDIN;
    logic sDOUT;
    logic syncRise_s;
    logic busIdle_s;

    assign sSYNC      = syncPipe_r[STAGES-1];
    assign sDIN       = dinPipe_r[STAGES-1];
    assign sDOUT      = doutPipe_r[STAGES-1];
    assign syncRise_s = syncPipe_r[0] & ~syncPipe_r[1];
    // Idle only once SYNC is low through the whole chain, so a freshly latched
    // address is not thrown away while the deeper stages still show the old low.
    assign busIdle_s  = ~sSYNC & ~(|syncPipe_r) & ~sDIN & ~sDOUT;

    assign DAL = DALtx ? {6'b000000, rdBuf_r} : {22{1'bz}};

    // Stage-1 capture of bus data and synchronisers for the handshake strobes.
    always_ff @(posedge qclk) begin
        if (!qrst_n) begin
            dalQ1_r    <= 16'h0000;
            bs7Q1_r    <= 1'b0;
            syncPipe_r <= {STAGES{1'b0}};
            dinPipe_r  <= {STAGES{1'b0}};
            doutPipe_r <= {STAGES{1'b0}};
        end else begin
            dalQ1_r    <= DAL[15:0];
            bs7Q1_r    <= RBS7;
            syncPipe_r <= {syncPipe_r[STAGES-2:0], RSYNC};
            dinPipe_r  <= {dinPipe_r[STAGES-2:0], RDIN};
            doutPipe_r <= {doutPipe_r[STAGES-2:0], RDOUT};
        end
    end

    // Bus cycle FSM with registered handshake and register-bus outputs.
    always_ff @(posedge qclk) begin
        if (!qrst_n) begin
            state_r <= IDLE;
            DALtx   <= 1'b0;
            TRPLY   <= 1'b0;
            iWRITE  <= 1'b0;
            iADDR   <= 13'h0000;
            iBS7    <= 1'b0;
            iWDATA  <= 16'h0000;
            rdBuf_r <= 16'h0000;
        end else begin
            iWRITE <= 1'b0;
            if (syncRise_s) begin
                iADDR   <= dalQ1_r[12:0];
                iBS7    <= bs7Q1_r;
                DALtx   <= 1'b0;
                TRPLY   <= 1'b0;
                state_r <= ADDR;
            end else if (busIdle_s) begin
                DALtx   <= 1'b0;
                TRPLY   <= 1'b0;
                state_r <= IDLE;
            end else begin
                case (state_r)
                    IDLE: begin
                        DALtx <= 1'b0;
                        TRPLY <= 1'b0;
                    end
                    ADDR: begin
                        // DIN wins over DOUT; the match lines only matter on this clock.
                        if (sDIN) begin
                            if (iREAD_MATCH) begin
                                rdBuf_r <= iRDATA;
                                DALtx   <= 1'b1;
                                TRPLY   <= RPLY_IMMEDIATE;
                                state_r <= READ;
                            end else begin
                                state_r <= NXM;
                            end
                        end else if (sDOUT) begin
                            if (iWRITE_MATCH) begin
                                iWDATA  <= dalQ1_r;
                                iWRITE  <= 1'b1;
                                TRPLY   <= RPLY_IMMEDIATE;
                                state_r <= WRITE;
                            end else begin
                                state_r <= NXM;
                            end
                        end else begin
                            state_r <= ADDR;
                        end
                    end
                    READ: begin
                        // Returning to ADDR rather than IDLE lets a DOUT follow in the same SYNC.
                        if (!sDIN) begin
                            DALtx   <= 1'b0;
                            TRPLY   <= 1'b0;
                            state_r <= ADDR;
                        end else begin
                            TRPLY <= 1'b1;
                        end
                    end
                    WRITE: begin
                        if (!sDOUT) begin
                            TRPLY   <= 1'b0;
                            state_r <= ADDR;
                        end else begin
                            TRPLY <= 1'b1;
                        end
                    end
                    NXM: begin
                        DALtx <= 1'b0;
                        TRPLY <= 1'b0;
                        if (!sDIN && !sDOUT) begin
                            state_r <= ADDR;
                        end else begin
                            state_r <= NXM;
                        end
                    end
                    default: begin
                        DALtx   <= 1'b0;
                        TRPLY   <= 1'b0;
                        state_r <= IDLE;
                    end
                endcase
            end
        end
    end

endmodule

// File: tb/tb_qbus_io_bridge.sv
// Directed bench for qbus_io_bridge: stimulus queues expected reads/writes, a monitor pops and compares them.
module tb_qbus_io_bridge;

`ifdef QBRIDGE_RPLY_DELAY_EN
    localparam int REPLY_EDGES = 4;
`else
    localparam int REPLY_EDGES = 3;
`endif
    localparam int RELEASE_EDGES = 3;

    logic        qclk;
    logic        qrst_n;
    logic        DALtx;
    wire  [21:0] DAL;
    logic        RBS7;
    logic        RSYNC;
    logic        RDIN;
    logic        RDOUT;
    logic        TRPLY;
    logic [12:0] iADDR;
    logic        iBS7;
    logic        iREAD_MATCH;
    logic        iWRITE_MATCH;
    logic [15:0] iWDATA;
    logic        iWRITE;
    logic [15:0] iRDATA;

    logic [21:0] tbDal;
    logic        tbDrive;
    logic [15:0] reg440;
    logic [15:0] reg560;
    logic [12:0] curAddr;

    typedef struct {
        bit          isWrite;
        logic [12:0] addr;
        logic [15:0] data;
    } exp_t;

    exp_t expQ[$];
    int   total = 0;
    int   bad   = 0;

    assign DAL = tbDrive ? tbDal : {22{1'bz}};

    qbus_io_bridge #(.SYNC_STAGES(2)) dut (
        .qclk(qclk), .qrst_n(qrst_n), .DALtx(DALtx), .DAL(DAL),
        .RBS7(RBS7), .RSYNC(RSYNC), .RDIN(RDIN), .RDOUT(RDOUT),
        .TRPLY(TRPLY), .iADDR(iADDR), .iBS7(iBS7),
        .iREAD_MATCH(iREAD_MATCH), .iWRITE_MATCH(iWRITE_MATCH),
        .iWDATA(iWDATA), .iWRITE(iWRITE), .iRDATA(iRDATA)
    );

    initial begin
        qclk = 1'b0;
        forever #25 qclk = ~qclk;
    end

    // Two I/O-page registers at 'o440 and 'o560, both powering up as 'o123456.
    assign iREAD_MATCH  = iBS7 && (iADDR == 13'o440 || iADDR == 13'o560);
    assign iWRITE_MATCH = iREAD_MATCH;
    assign iRDATA       = (iADDR == 13'o560) ? reg560 : reg440;

    initial begin
        reg440 = 16'o123456;
        reg560 = 16'o123456;
    end

    always @(posedge qclk) begin
        if (iWRITE && iBS7 && iADDR == 13'o440) reg440 <= iWDATA;
        if (iWRITE && iBS7 && iADDR == 13'o560) reg560 <= iWDATA;
    end

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        total++;
        if (act !== req) begin
            bad++;
            $display("FAIL %s: actual=%0h required=%0h", name, act, req);
        end
    endtask

    task automatic checkMax(input string name, input int act, input int maxv);
        total++;
        if (act > maxv) begin
            bad++;
            $display("FAIL %s: actual=%0d edges required<=%0d", name, act, maxv);
        end
    endtask

    // Monitor: every write strobe and every read reply pops one expected entry.
    initial begin
        logic trplyPrev;
        exp_t e;
        trplyPrev = 1'b0;
        forever begin
            @(negedge qclk);
            if (iWRITE) begin
                total++;
                if (expQ.size() == 0) begin
                    bad++;
                    $display("FAIL spuriousWrite: actual=write of %0o to %0o required=no write", iWDATA, iADDR);
                end else begin
                    e = expQ.pop_front();
                    check("writeKind", {31'd0, e.isWrite}, 32'd1);
                    check("writeData", {16'd0, iWDATA}, {16'd0, e.data});
                    check("writeAddr", {19'd0, iADDR}, {19'd0, e.addr});
                end
            end
            if (TRPLY && !trplyPrev && DALtx) begin
                total++;
                if (expQ.size() == 0) begin
                    bad++;
                    $display("FAIL spuriousRead: actual=read reply %0o required=no reply", DAL[15:0]);
                end else begin
                    e = expQ.pop_front();
                    check("readKind", {31'd0, e.isWrite}, 32'd0);
                    check("readData", {16'd0, DAL[15:0]}, {16'd0, e.data});
                    check("readHigh", {26'd0, DAL[21:16]}, 32'd0);
                end
            end
            trplyPrev = TRPLY;
        end
    end

    task automatic startCycle(input logic bs7, input logic [12:0] addr);
        @(negedge qclk);
        curAddr = addr;
        tbDal   = {9'd0, addr};
        tbDrive = 1'b1;
        RBS7    = bs7;
        @(negedge qclk);
        RSYNC = 1'b1;
        repeat (3) @(negedge qclk);
        tbDrive = 1'b0;
        RBS7    = 1'b0;
        check("addrLatch", {19'd0, iADDR}, {19'd0, addr});
        check("bs7Latch", {31'd0, iBS7}, {31'd0, bs7});
    endtask

    task automatic dinPhase(input logic expReply, input logic [15:0] expData);
        int   n;
        logic seen;
        n    = 0;
        seen = 1'b0;
        if (expReply) expQ.push_back('{1'b0, curAddr, expData});
        RDIN = 1'b1;
        if (expReply) begin
            while (TRPLY !== 1'b1 && n < 8) begin
                @(negedge qclk);
                n++;
            end
            checkMax("dinReplyEdges", n, REPLY_EDGES);
            check("dinDaltx", {31'd0, DALtx}, 32'd1);
            repeat (2) @(negedge qclk);
            RDIN = 1'b0;
            n = 0;
            while ((TRPLY !== 1'b0 || DALtx !== 1'b0) && n < 8) begin
                @(negedge qclk);
                n++;
            end
            checkMax("dinRelease", n, RELEASE_EDGES);
        end else begin
            repeat (8) begin
                @(negedge qclk);
                if (TRPLY || DALtx) seen = 1'b1;
            end
            check("nxmQuiet", {31'd0, seen}, 32'd0);
            RDIN = 1'b0;
            repeat (4) @(negedge qclk);
        end
    endtask

    task automatic doutPhase(input logic [15:0] data, input logic expReply);
        int   n;
        logic seen;
        n    = 0;
        seen = 1'b0;
        if (expReply) expQ.push_back('{1'b1, curAddr, data});
        tbDal   = {6'd0, data};
        tbDrive = 1'b1;
        RDOUT   = 1'b1;
        if (expReply) begin
            while (TRPLY !== 1'b1 && n < 8) begin
                @(negedge qclk);
                n++;
            end
            checkMax("doutReplyEdges", n, REPLY_EDGES);
            repeat (2) @(negedge qclk);
            RDOUT = 1'b0;
            n = 0;
            while (TRPLY !== 1'b0 && n < 8) begin
                @(negedge qclk);
                n++;
            end
            checkMax("doutRelease", n, RELEASE_EDGES);
        end else begin
            repeat (8) begin
                @(negedge qclk);
                if (TRPLY || DALtx) seen = 1'b1;
            end
            check("nxmWriteQuiet", {31'd0, seen}, 32'd0);
            RDOUT = 1'b0;
            repeat (4) @(negedge qclk);
        end
        tbDrive = 1'b0;
    endtask

    task automatic endCycle();
        RSYNC = 1'b0;
        repeat (4) @(negedge qclk);
    endtask

    initial begin
        #200us;
        $display("FAIL watchdog: actual=timeout required=completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        int n;
        qrst_n  = 1'b0;
        RBS7    = 1'b0;
        RSYNC   = 1'b0;
        RDIN    = 1'b0;
        RDOUT   = 1'b0;
        tbDal   = 22'd0;
        tbDrive = 1'b0;
        curAddr = 13'd0;
        repeat (3) @(negedge qclk);
        check("rstDaltx", {31'd0, DALtx}, 32'd0);
        check("rstTrply", {31'd0, TRPLY}, 32'd0);
        check("rstWrite", {31'd0, iWRITE}, 32'd0);
        check("rstAddr", {19'd0, iADDR}, 32'd0);
        check("rstBs7", {31'd0, iBS7}, 32'd0);
        check("rstWdata", {16'd0, iWDATA}, 32'd0);
        qrst_n = 1'b1;
        @(negedge qclk);

        // Plain reads and both flavours of unclaimed address.
        startCycle(1'b1, 13'o440); dinPhase(1'b1, 16'o123456); endCycle();
        startCycle(1'b1, 13'o400); dinPhase(1'b0, 16'o0);      endCycle();
        startCycle(1'b0, 13'o440); dinPhase(1'b0, 16'o0);      endCycle();

        // Write then read back.
        startCycle(1'b1, 13'o440); doutPhase(16'o054321, 1'b1); endCycle();
        startCycle(1'b1, 13'o440); dinPhase(1'b1, 16'o054321);  endCycle();

        // DATIO: read then write within one SYNC, then read the new value.
        startCycle(1'b1, 13'o560);
        dinPhase(1'b1, 16'o123456);
        doutPhase(16'o054545, 1'b1);
        endCycle();
        startCycle(1'b1, 13'o560); dinPhase(1'b1, 16'o054545); endCycle();

        // Reset while the bridge is driving a read reply.
        startCycle(1'b1, 13'o440);
        expQ.push_back('{1'b0, 13'o440, 16'o054321});
        RDIN = 1'b1;
        n = 0;
        while (TRPLY !== 1'b1 && n < 8) begin
            @(negedge qclk);
            n++;
        end
        checkMax("rstReadReplyEdges", n, REPLY_EDGES);
        qrst_n = 1'b0;
        @(negedge qclk);
        check("midRstDaltx", {31'd0, DALtx}, 32'd0);
        check("midRstTrply", {31'd0, TRPLY}, 32'd0);
        check("midRstAddr", {19'd0, iADDR}, 32'd0);
        RDIN  = 1'b0;
        RSYNC = 1'b0;
        repeat (3) @(negedge qclk);
        qrst_n = 1'b1;
        repeat (2) @(negedge qclk);
        startCycle(1'b1, 13'o440); dinPhase(1'b1, 16'o054321); endCycle();

        // Write to an unclaimed address must not strobe or reply.
        startCycle(1'b1, 13'o400); doutPhase(16'o000001, 1'b0); endCycle();

        repeat (4) @(negedge qclk);
        check("queueEmpty", expQ.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
